// File: rtl/apb_regfile_pkg.sv
// Shared types and the register map for the APB student-record register slave.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] ADDR_NUM     = 32'h00;
    localparam logic [31:0] ADDR_DATE    = 32'h04;
    localparam logic [31:0] ADDR_SURNAME = 32'h08;
    localparam logic [31:0] ADDR_NAME    = 32'h0C;
    localparam logic [31:0] ADDR_STATUS  = 32'h10;
    localparam logic [31:0] ADDR_ID      = 32'h14;
    localparam logic [31:0] ADDR_LIMIT   = 32'h18;

    localparam logic [31:0] ID_DEFAULT   = 32'hA9B0_0001;

endpackage

// File: rtl/apb_regfile_bank.sv
// Register storage, address decode, error classification and transfer counters.
module apb_regfile_bank
    import apb_regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    input  logic [31:0]       wdata,
    input  logic              commit,
    output logic [31:0]       rdata,
    output logic              err
);

    logic [3:0][31:0] regs_q;
    logic [7:0]       wr_cnt_q;
    logic [7:0]       err_cnt_q;
    logic [4:0]       off;
    logic             misaligned;
    logic             out_of_range;
    logic             read_only;

    assign off = addr[4:0];

    always_comb begin
        misaligned   = |addr[1:0];
        out_of_range = addr >= ADDR_W'(ADDR_LIMIT);
        read_only    = (off == ADDR_STATUS[4:0]) || (off == ADDR_ID[4:0]);
        err          = misaligned || out_of_range || (write && read_only);
    end

    // Error responses always carry zero data, so the mux is gated by err.
    always_comb begin
        rdata = '0;
        if (!err) begin
            case (off)
                ADDR_NUM[4:0], ADDR_DATE[4:0],
                ADDR_SURNAME[4:0], ADDR_NAME[4:0]: rdata = regs_q[off[3:2]];
                ADDR_STATUS[4:0]:                  rdata = {16'h0, err_cnt_q, wr_cnt_q};
                ADDR_ID[4:0]:                      rdata = ID_VALUE;
                default:                           rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q    <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (commit) begin
            if (err) begin
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (write) begin
                regs_q[off[3:2]] <= wdata;
                wr_cnt_q         <= wr_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 completer for the student-record registers: transfer FSM with programmable wait states.
module apb_regfile_slave
    import apb_regfile_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_d, slverr_d;
    logic [31:0]       rdata_d;

    logic [ADDR_W-1:0] dec_addr;
    logic              dec_write;
    logic              commit;
    logic [31:0]       bank_rdata;
    logic              bank_err;

    // Zero-wait builds respond on the setup edge, so decode the live bus while idle.
    assign dec_addr  = (state_q == IDLE) ? PADDR  : addr_q;
    assign dec_write = (state_q == IDLE) ? PWRITE : write_q;

    apb_regfile_bank #(
        .ADDR_W   (ADDR_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk    (PCLK),
        .rst    (PRESET),
        .addr   (dec_addr),
        .write  (dec_write),
        .wdata  (wdata_q),
        .commit (commit),
        .rdata  (bank_rdata),
        .err    (bank_err)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        ready_d  = 1'b0;
        rdata_d  = '0;
        slverr_d = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        rdata_d  = bank_rdata;
                        slverr_d = bank_err;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        rdata_d  = bank_rdata;
                        slverr_d = bank_err;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // A master that drops PSEL here abandons the transfer: nothing commits.
                state_d = IDLE;
                commit  = PSEL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            PREADY  <= ready_d;
            PRDATA  <= rdata_d;
            PSLVERR <= slverr_d;
        end
    end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
APB3 completer (responder) for the student-record register set addressed by the team's apb_master.
- Four read/write registers: number_in_group, date, surname, name.
- Two read-only registers: transfer statistics and block ID.
- Programmable wait states via PREADY; error response via PSLVERR.
- Sits directly on apb_master's PSEL/PENABLE/PADDR/PWRITE/PWDATA bus and drives PRDATA/PREADY back.

Parameters:
ADDR_W, 32, width of PADDR
WAIT_STATES, 1, number of access-phase cycles with PREADY low before completion (0 = zero-wait)
ID_VALUE, 32'hA9B0_0001, constant returned by the ID register

Ports:
PCLK  in  1  clock, all state updates on rising edge
PRESET  in  1  reset, asynchronous, active-high
PSEL  in  1  slave select from master
PENABLE  in  1  access-phase indicator from master
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  32  write data
PRDATA  out  32  read data, valid only while PREADY=1
PREADY  out  1  transfer completion
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Register map (byte offsets):
  - 0x00 NUM_IN_GROUP, RW
  - 0x04 DATE, RW
  - 0x08 SURNAME, RW
  - 0x0C NAME, RW
  - 0x10 STATUS, RO: [7:0] successful-write count, [15:8] error count, [31:16] zero
  - 0x14 ID, RO: ID_VALUE
- Reset (async, PRESET=1): all RW registers 0; both counters 0; state IDLE; PREADY=0, PRDATA=0, PSLVERR=0. All outputs are registered.
- FSM states IDLE, WAIT, DONE:
  - IDLE: on an edge sampling PSEL=1 and PENABLE=0 (setup), latch PADDR, PWRITE and PWDATA; load cnt=WAIT_STATES.
    - WAIT_STATES=0: go to DONE, with PREADY/PRDATA/PSLVERR registered high/valid on that same edge.
    - Otherwise: go to WAIT.
  - WAIT: PREADY=0. On each edge with PSEL=1 and PENABLE=1, decrement cnt. When cnt reaches 1, go to DONE and register the response.
  - DONE: PREADY=1 for exactly one cycle; the transfer completes on this edge. Return to IDLE with PREADY, PRDATA and PSLVERR cleared to 0.
- Completion latency from the setup edge is WAIT_STATES+1 cycles; a back-to-back setup is accepted on the cycle after DONE.
- Errors (PSLVERR=1 with PREADY=1):
  - PADDR[1:0]!=0
  - PADDR >= 0x18
  - write to 0x10 or 0x14
- Error transfer side effects:
  - No register is modified.
  - Read PRDATA=0.
  - Error count increments, saturating at 255.
- Write commit: a successful write updates the target register on the DONE edge, and the write count increments with wrap (255 -> 0).
- Read data: taken from register contents at the response edge.
- Simultaneous events:
  - A STATUS read returns counter values from before the current transfer.
  - The counters update on the DONE edge.
- Protocol violation: PSEL=0 while in WAIT or DONE aborts the transfer. Return to IDLE; no write and no counter change; outputs cleared.
- PENABLE=0 while PSEL=1 in WAIT: cnt holds (no decrement).
- Reset mid-transfer: immediate return to IDLE; in-flight write discarded.
- PRDATA and PSLVERR are 0 whenever PREADY=0.

Decomposition:
- Package apb_regfile_pkg holds:
  - state enum (IDLE/WAIT/DONE)
  - address offset constants ADDR_NUM, ADDR_DATE, ADDR_SURNAME, ADDR_NAME, ADDR_STATUS, ADDR_ID
  - ADDR_LIMIT=0x18
  - default ID constant
- One sub-module, apb_regfile_bank: register storage, address decode, error classification and counters.
- The top level keeps the FSM and wait counter.

Test Plan:
- WAIT_STATES=1, write 24 to 0x00 then read 0x00 -> PREADY high on 2nd access cycle each time, PRDATA=32'd24, PSLVERR=0.
- Write 32'h13122023 to 0x04, 32'h53686B61 to 0x08, 32'h44656E69 to 0x0C; read back all three -> exact values; read 0x10 -> STATUS=32'h0000_0004.
- Write 0x10, read 0x20, read 0x06 -> each PSLVERR=1, PRDATA=0; subsequent STATUS[15:8]=3, RW registers unchanged.
- Drop PSEL during WAIT of a write of 32'hDEADBEEF to 0x00 -> PREADY never asserts, register keeps prior value, counters unchanged; next transfer completes normally.
- Assert PRESET mid-WAIT -> outputs 0 immediately (before next edge), all registers read 0 afterward.
- 256 successful writes -> STATUS[7:0] wraps to 0; 260 errors -> STATUS[15:8]=255; WAIT_STATES=0 build -> PREADY in first access cycle.
